clock_mode_ctrl: RTL
====================

Name: clock_mode_ctrl

Overview:
- Top-level mode/edit sequencer for the multimodal digital clock.
- Turns three synchronized, debounced pushbutton levels into:
  - the 2-bit display mode,
  - an edit-field select,
  - one-cycle increment, commit and start/stop strobes,
  - a blink enable.
- Drives the mode select of the AM/PM output stage and the time/alarm/stopwatch/timer datapaths.

Parameters:
- TIMEOUT_S, 10: seconds of button inactivity in edit before abort to RUN; range 1..255.
- REPEAT_DELAY, 25000000: clk cycles btn_inc must be held before the first auto-repeat (optional feature only).
- REPEAT_RATE, 5000000: clk cycles between auto-repeat pulses (optional feature only).

Ports:
- clk  input  1  system clock
- reset  input  1  reset reset, synchronous, active-low
- tick_1hz  input  1  one-cycle strobe, once per second
- btn_mode  input  1  debounced level, 1 = pressed
- btn_set  input  1  debounced level, 1 = pressed
- btn_inc  input  1  debounced level, 1 = pressed
- mode  output  2  00 time, 01 alarm, 10 stopwatch, 11 timer
- edit  output  1  1 while in EDIT_HR or EDIT_MIN
- field  output  2  00 hours, 01 minutes, 11 none (RUN)
- inc_pulse  output  1  one-cycle increment of the selected field
- commit  output  1  one-cycle strobe: store edited value
- sw_toggle  output  1  one-cycle start/stop strobe for stopwatch/timer
- blink  output  1  display blink enable for the selected field
- ap_en  output  1  AM/PM indicator valid: 1 when mode is 00 or 01

Behaviour:
- **Edge detection**
  - One previous-value register per button.
  - A press is cycle N where btn is 1 and prev is 0.
  - prev registers reset to 1, so a button held through reset does not fire.
- **Registered outputs**
  - Every output is registered.
  - The response to a press at cycle N is visible in cycle N+1.
  - Strobes are exactly 1 cycle wide.
- **Reset values** (while reset = 0 at a clk edge)
  - mode = 00, state RUN, edit = 0, field = 11.
  - inc_pulse = commit = sw_toggle = 0, blink = 0, ap_en = 1.
  - Timeout counter = 0, repeat counter = 0.
  - Reset mid-edit aborts with no commit.
- **States:** RUN, EDIT_HR, EDIT_MIN.
- **RUN**
  - set press with mode 00/01 -> EDIT_HR; blink cleared to 0, timeout counter cleared.
  - set press with mode 10/11 -> sw_toggle pulse; stay in RUN.
  - mode press -> mode+1, with 11 wrapping to 00.
  - inc press ignored.
  - set and mode pressed in the same cycle: set wins, mode press is discarded.
- **EDIT_HR**
  - inc press -> inc_pulse with field = 00.
  - set press -> EDIT_MIN.
  - mode press ignored; mode is frozen during edit.
- **EDIT_MIN**
  - inc press -> inc_pulse with field = 01.
  - set press -> RUN plus a commit pulse in the same cycle that edit falls to 0.
  - commit is qualified by the mode value held throughout the edit.
- **Simultaneous presses in edit:** set and inc in the same cycle -> set wins, no inc_pulse.
- **Timeout**
  - Counter increments on tick_1hz while edit = 1.
  - Any press in edit (mode, set or inc) clears it.
  - If a press and a tick arrive in the same cycle, the clear wins.
  - When the counter reaches TIMEOUT_S: go to RUN, no commit, field = 11, blink = 0.
  - Counter width is 8 bits; it saturates rather than wrapping.
- **Blink**
  - Toggles on each tick_1hz while edit = 1.
  - Forced to 0 in RUN.
  - Entering edit starts at 0.
- **ap_en:** combinational decode of the registered mode; it is still driven from a register, since mode is a register.

Optional Feature:
- **Macro:** CLOCK_MODE_CTRL_AUTO_REPEAT_EN.
- **Defined:**
  - In EDIT_HR/EDIT_MIN, btn_inc held continuously for REPEAT_DELAY cycles after its press produces an inc_pulse.
  - A further inc_pulse follows every REPEAT_RATE cycles while it remains held.
  - Each repeat pulse also clears the timeout counter.
  - Release, a set press, a state change, or reset clears the repeat counter.
  - A repeat pulse and a set press in the same cycle: set wins.
- **Not defined:**
  - The repeat counter and its logic are absent.
  - Holding btn_inc yields exactly one inc_pulse.

Test Plan:
1. Reset, then 4 mode presses spaced 3 cycles apart -> mode 01, 10, 11, 00, each one cycle after its press; ap_en is 1,0,0,1.
2. mode = 00; set, inc, inc, set, inc, set -> field 00 with 2 inc_pulses, then field 01 with 1 inc_pulse, then commit pulse; edit = 0, field = 11.
3. mode = 10; set press -> single sw_toggle, edit stays 0. Set and mode pressed in the same cycle -> sw_toggle only, mode stays 10.
4. TIMEOUT_S = 3, enter edit, apply 3 tick_1hz with no presses:
   - blink reads 1,0,1 after the three ticks.
   - The 3rd tick returns to RUN with commit = 0 and blink = 0.
   - Repeat with an inc press on tick 2 -> timeout only after 3 further ticks.
5. Hold btn_set through reset release -> no transition. Assert reset during EDIT_MIN -> mode = 00, RUN, no commit.
6. With the macro defined, REPEAT_DELAY = 10, REPEAT_RATE = 4; hold inc for 30 cycles in EDIT_HR -> inc_pulses at press+1, +10, +14, +18, +22, +26, +30 relative cycles. Without the macro -> 1 pulse.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// Mode/edit sequencer for the multimodal digital clock: button edges -> mode, edit field, strobes, blink.
// Optional inc auto-repeat is compiled in with `define CLOCK_MODE_CTRL_AUTO_REPEAT_EN.
module clock_mode_ctrl #(
  parameter int unsigned TIMEOUT_S    = 10,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       btn_inc,
  output logic [1:0] mode,
  output logic       edit,
  output logic [1:0] field,
  output logic       inc_pulse,
  output logic       commit,
  output logic       sw_toggle,
  output logic       blink,
  output logic       ap_en
);

  typedef enum logic [1:0] {
    S_RUN      = 2'b00,
    S_EDIT_HR  = 2'b01,
    S_EDIT_MIN = 2'b10
  } state_e;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_S);

  state_e     state_q, state_d;
  logic [2:0] prev_q, prev_d;   // {inc, set, mode}
  logic [1:0] mode_q, mode_d;
  logic [7:0] tmo_q, tmo_d;
  logic       blink_q, blink_d;
  logic       inc_pulse_q, inc_pulse_d;
  logic       commit_q, commit_d;
  logic       sw_toggle_q, sw_toggle_d;

  logic press_mode, press_set, press_inc;
  logic in_edit, timed_out, rpt_fire;

  assign prev_d     = {btn_inc, btn_set, btn_mode};
  assign press_mode = btn_mode & ~prev_q[0];
  assign press_set  = btn_set  & ~prev_q[1];
  assign press_inc  = btn_inc  & ~prev_q[2];

  assign in_edit   = (state_q != S_RUN);
  assign timed_out = in_edit && (tmo_q >= TMO_LIMIT);

`ifdef CLOCK_MODE_CTRL_AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;

  // Down-counter: 0 = idle; fires when it reaches 1, then reloads the repeat period.
  always_comb begin
    rpt_d    = '0;
    rpt_fire = 1'b0;
    if (in_edit && !timed_out && !press_set) begin
      if (press_inc) begin
        rpt_d = RPT_W'(REPEAT_DELAY - 1);
      end else if (btn_inc && (rpt_q != '0)) begin
        if (rpt_q == RPT_W'(1)) begin
          rpt_fire = 1'b1;
          rpt_d    = RPT_W'(REPEAT_RATE);
        end else begin
          rpt_d = rpt_q - RPT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) rpt_q <= '0;
    else        rpt_q <= rpt_d;
  end
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = (REPEAT_DELAY != 0) ^ (REPEAT_RATE != 0);
  assign rpt_fire       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_RUN;
      prev_q      <= '1;
      mode_q      <= 2'b00;
      tmo_q       <= '0;
      blink_q     <= 1'b0;
      inc_pulse_q <= 1'b0;
      commit_q    <= 1'b0;
      sw_toggle_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      mode_q      <= mode_d;
      tmo_q       <= tmo_d;
      blink_q     <= blink_d;
      inc_pulse_q <= inc_pulse_d;
      commit_q    <= commit_d;
      sw_toggle_q <= sw_toggle_d;
    end
  end

  // Timeout abort outranks any press seen in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:      if (press_set && !mode_q[1]) state_d = S_EDIT_HR;
      S_EDIT_HR:  if (timed_out)               state_d = S_RUN;
                  else if (press_set)          state_d = S_EDIT_MIN;
      S_EDIT_MIN: if (timed_out || press_set)  state_d = S_RUN;
      default:                                 state_d = S_RUN;
    endcase
  end

  always_comb begin
    mode_d      = mode_q;
    inc_pulse_d = 1'b0;
    commit_d    = 1'b0;
    sw_toggle_d = 1'b0;
    blink_d     = 1'b0;
    tmo_d       = '0;
    if (state_q == S_RUN) begin
      if (press_set)       sw_toggle_d = mode_q[1];
      else if (press_mode) mode_d      = mode_q + 2'd1;
    end else if (!timed_out) begin
      inc_pulse_d = !press_set && (press_inc || rpt_fire);
      commit_d    = press_set && (state_q == S_EDIT_MIN);
      blink_d     = (state_d != S_RUN) && (blink_q ^ tick_1hz);
      if (press_mode || press_set || press_inc || rpt_fire) tmo_d = '0;
      else if (tick_1hz && (tmo_q != 8'hFF))                tmo_d = tmo_q + 8'd1;
      else                                                  tmo_d = tmo_q;
    end
  end

  assign mode      = mode_q;
  assign edit      = in_edit;
  assign field     = (state_q == S_EDIT_HR)  ? 2'b00 :
                     (state_q == S_EDIT_MIN) ? 2'b01 : 2'b11;
  assign inc_pulse = inc_pulse_q;
  assign commit    = commit_q;
  assign sw_toggle = sw_toggle_q;
  assign blink     = blink_q;
  assign ap_en     = ~mode_q[1];

endmodule
